aqua_mem_responder: RTL and testbench
=====================================

AQUA_MEM_RESPONDER -- requirements
Module: aqua_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DATA_WIDTH, default 32, meaning the data bus width in bits.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 32, meaning the byte-address bus width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, meaning the storage depth in words (power of two).
REQ-004 SHALL have parameter LATENCY, default 2, meaning the number of busy cycles per access (legal range 1..15).
REQ-005 SHALL use one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 memAddr  input  MEM_ADDR_WIDTH  byte address from the arbiter.
REQ-009 memWr  input  1  1 = write, 0 = read.
REQ-010 memReq  input  1  access request.
REQ-011 memDataIn  input  MEM_DATA_WIDTH  write data.
REQ-012 memBusyOut  output  1  responder is servicing an access; new requests are ignored.
REQ-013 memDataOut  output  MEM_DATA_WIDTH  read data, registered.
REQ-014 memDone  output  1  one-cycle pulse when an access completes.
REQ-015 memErr  output  1  one-cycle pulse, together with memDone, when the address is out of range or misaligned.

Function
REQ-016 SHALL implement the FSM states IDLE and BUSY.
REQ-017 In IDLE with memReq=1, the rising edge SHALL capture memAddr/memWr/memDataIn into internal registers, load the counter with LATENCY-1, and enter BUSY.
REQ-018 memBusyOut SHALL be 1 exactly while in BUSY, i.e. for LATENCY cycles per access.
REQ-019 In BUSY the counter SHALL decrement each edge; on the edge where it equals 0 the access SHALL execute, memDone SHALL pulse and the FSM SHALL return to IDLE.
REQ-020 A read SHALL load memDataOut on the completing edge; memDataOut SHALL hold that value until the next completed read (writes do not change it).
REQ-021 A write SHALL commit the captured data on the completing edge, never earlier.
REQ-022 The word index SHALL be captured_addr[log2(DEPTH_WORDS)+1:2].
REQ-023 An address with bits [1:0] != 0, or with a byte address at or above DEPTH_WORDS*4, SHALL be an error: writes are dropped, reads return 0, and memErr pulses.
REQ-024 memReq, memAddr, memWr and memDataIn changes during BUSY SHALL be ignored.
REQ-025 Back-to-back: a request present in the first IDLE cycle after completion SHALL be accepted on that edge (one idle cycle minimum between accesses).
REQ-026 Read-after-write to the same word SHALL return the newly written data.

Reset
REQ-027 Reset SHALL asynchronously force state=IDLE, counter=0, memBusyOut=0, memDone=0, memErr=0 and memDataOut=0.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted during BUSY SHALL abort the access, and a pending write SHALL NOT commit.

Structure
REQ-030 The FSM state encodings and the LATENCY counter width (4) SHALL live in a shared header of defines used by the memory-side blocks.
REQ-031 The storage array SHALL be a sub-module aqua_sram1rw (single port, synchronous write, registered read, DEPTH_WORDS x MEM_DATA_WIDTH).

Verification
REQ-032 Write 0xDEADBEEF to 0x10, then read 0x10 -> memBusyOut high for exactly 2 cycles each, and after the read memDataOut=0xDEADBEEF with memDone pulsing once per access.
REQ-033 LATENCY=1: write 0x1 to 0x0, then read in the immediately following idle cycle -> read accepted with no gap beyond REQ-025, and memDataOut=0x1.
REQ-034 Read 0x1002 (misaligned) and write 0x5555 to 0x1000 (DEPTH 1024 -> out of range) -> memErr and memDone pulse together; the read returns 0; a later read of 0x0 is unchanged.
REQ-035 Toggle memAddr/memWr/memDataIn and hold memReq=1 during BUSY -> only the originally captured access executes, and the next access is accepted only after memBusyOut falls.
REQ-036 Write 0xAAAA to 0x20, then assert reset mid-BUSY on a write of 0xBBBB to 0x20 -> all outputs 0 immediately; a subsequent read of 0x20 returns 0xAAAA.

Source files
------------

// File: rtl/aqua_mem_responder_pkg.sv
// aqua_mem_responder_pkg
//   Shared definitions for the memory-side blocks. It holds the responder FSM
//   state encoding, the latency counter width, and a helper that converts a
//   LATENCY value into the counter preload.
package aqua_mem_responder_pkg;

  // Width of the busy-cycle counter. It covers LATENCY values 1..15.
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // The counter is preloaded with LATENCY-1. The access then executes on the
  // edge where the counter reads 0, which gives LATENCY busy cycles.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/aqua_sram1rw.sv
// aqua_sram1rw
//   Single-port storage array with a synchronous write and a registered read.
//   Nothing inside the array is reset.
//   Ports:
//     clk   - rising-edge clock
//     en    - port enable (read when we=0, write when we=1)
//     we    - write enable
//     addr  - word index
//     wdata - write data
//     rdata - registered read data. It holds its value until the next read.
module aqua_sram1rw #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/aqua_mem_responder.sv
// aqua_mem_responder
//   Fixed-latency memory responder that sits behind an arbiter. When it
//   accepts a request it captures the request, stays busy for LATENCY cycles,
//   and then executes the access. On completion it pulses memDone, together
//   with memErr if the address was misaligned or out of range.
//   Ports:
//     clk, reset  - clock and asynchronous active-high reset
//     memAddr     - byte address
//     memWr       - 1 = write, 0 = read
//     memReq      - access request. It is sampled only while idle.
//     memDataIn   - write data
//     memBusyOut  - high for the LATENCY cycles of an access
//     memDataOut  - registered read data. It is updated only by completed reads.
//     memDone     - one-cycle completion pulse
//     memErr      - one-cycle error pulse, aligned with memDone
//   LATENCY must be in the range 1..15.
module aqua_mem_responder
  import aqua_mem_responder_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MEM_ADDR_WIDTH-1:0] memAddr,
  input  logic                      memWr,
  input  logic                      memReq,
  input  logic [MEM_DATA_WIDTH-1:0] memDataIn,
  output logic                      memBusyOut,
  output logic [MEM_DATA_WIDTH-1:0] memDataOut,
  output logic                      memDone,
  output logic                      memErr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [MEM_DATA_WIDTH-1:0] dout_q, dout_d;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    bad_q, bad_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic                      req_bad, req_accept, complete;
  logic                      sram_en, sram_we;
  logic [IDX_W-1:0]          sram_addr;
  logic [MEM_DATA_WIDTH-1:0] sram_rdata;

  // An address is bad if it is misaligned or if any bit at or above the
  // top of the array (DEPTH_WORDS*4 bytes) is set.
  assign req_bad    = (memAddr[1:0] != 2'b00) || ((memAddr >> (IDX_W + 2)) != '0);
  assign req_accept = (state_q == ST_IDLE) && memReq;
  assign complete   = (state_q == ST_BUSY) && (cnt_q == '0);

  // The array read is issued on the accept edge. This way the registered
  // read data is already stable when the completing edge loads memDataOut,
  // even when LATENCY is 1. A write goes to the array only on the completing
  // edge, so a reset during BUSY leaves the array untouched.
  assign sram_we   = complete && wr_q && !bad_q;
  assign sram_en   = req_accept || sram_we;
  assign sram_addr = req_accept ? memAddr[IDX_W+1:2] : idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dout_d  = dout_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (memReq) begin
          wr_d    = memWr;
          wdata_d = memDataIn;
          idx_d   = memAddr[IDX_W+1:2];
          bad_d   = req_bad;
          cnt_d   = lat_load(LATENCY);
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          err_d   = bad_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (!wr_q) dout_d = bad_q ? '0 : sram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
    end
  end

  aqua_sram1rw #(
    .DEPTH(DEPTH_WORDS),
    .WIDTH(MEM_DATA_WIDTH)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .wdata(wdata_q),
    .rdata(sram_rdata)
  );

  assign memBusyOut = busy_q;
  assign memDataOut = dout_q;
  assign memDone    = done_q;
  assign memErr     = err_q;

endmodule

// File: tb/tb_aqua_mem_responder.sv
// Directed bench for aqua_mem_responder.
//   Instance 0 uses the defaults (LATENCY=2).
//   Instance 1 uses LATENCY=1.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_aqua_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_i [2];
  logic        wr_i   [2];
  logic        req_i  [2];
  logic [31:0] din_i  [2];
  logic        busy_o [2];
  logic [31:0] dout_o [2];
  logic        done_o [2];
  logic        err_o  [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aqua_mem_responder u_dut0 (
    .clk(clk), .reset(reset), .memAddr(addr_i[0]), .memWr(wr_i[0]),
    .memReq(req_i[0]), .memDataIn(din_i[0]), .memBusyOut(busy_o[0]),
    .memDataOut(dout_o[0]), .memDone(done_o[0]), .memErr(err_o[0])
  );

  aqua_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .memAddr(addr_i[1]), .memWr(wr_i[1]),
    .memReq(req_i[1]), .memDataIn(din_i[1]), .memBusyOut(busy_o[1]),
    .memDataOut(dout_o[1]), .memDone(done_o[1]), .memErr(err_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The caller must be at a falling edge. This task drives one request for a
  // single cycle and then samples each following falling edge until memDone is
  // seen, for at most 20 cycles. It returns at the falling edge where memDone
  // is high, which is the first idle cycle. It reports the busy cycles seen,
  // the done and err pulses seen, err at the done cycle, and the total cycles.
  task automatic access(input int s, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int nb, output int nd,
                        output int ne, output int err_at_done, output int nc);
    req_i[s] = 1'b1; wr_i[s] = wr; addr_i[s] = a; din_i[s] = d;
    @(negedge clk);
    req_i[s] = 1'b0;
    nb = 0; nd = 0; ne = 0; err_at_done = 0; nc = 1;
    for (int i = 0; i < 20; i++) begin
      if (busy_o[s]) nb++;
      if (err_o[s])  ne++;
      if (done_o[s]) begin
        nd++;
        err_at_done = int'(err_o[s]);
        break;
      end
      @(negedge clk);
      nc++;
    end
  endtask

  initial begin
    int nb, nd, ne, ead, nc;
    for (int s = 0; s < 2; s++) begin
      addr_i[s] = '0; wr_i[s] = 1'b0; req_i[s] = 1'b0; din_i[s] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(busy_o[0]), 32'd0);
    chk("rst_done0", 32'(done_o[0]), 32'd0);
    chk("rst_err0",  32'(err_o[0]),  32'd0);
    chk("rst_dout0", dout_o[0],      32'd0);
    chk("rst_busy1", 32'(busy_o[1]), 32'd0);
    chk("rst_dout1", dout_o[1],      32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write then read with LATENCY=2
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, nb, nd, ne, ead, nc);
    chk("wr10_busy", 32'(nb), 32'd2);
    chk("wr10_done", 32'(nd), 32'd1);
    chk("wr10_err",  32'(ne), 32'd0);
    chk("wr10_dout", dout_o[0], 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, nb, nd, ne, ead, nc);
    chk("rd10_busy", 32'(nb), 32'd2);
    chk("rd10_done", 32'(nd), 32'd1);
    chk("rd10_cyc",  32'(nc), 32'd3);
    chk("rd10_data", dout_o[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("rd10_pulse1", 32'(done_o[0]), 32'd0);
    chk("rd10_idle",   32'(busy_o[0]), 32'd0);

    // LATENCY=1 back-to-back write then read
    access(1, 1'b1, 32'h0, 32'h1, nb, nd, ne, ead, nc);
    chk("l1_wr_busy", 32'(nb), 32'd1);
    chk("l1_wr_done", 32'(nd), 32'd1);
    access(1, 1'b0, 32'h0, 32'h0, nb, nd, ne, ead, nc);
    chk("l1_rd_busy", 32'(nb), 32'd1);
    chk("l1_rd_cyc",  32'(nc), 32'd2);
    chk("l1_rd_data", dout_o[1], 32'h1);

    // Inputs toggle during BUSY while memReq stays high
    req_i[0] = 1'b1; wr_i[0] = 1'b1; addr_i[0] = 32'h40; din_i[0] = 32'h1234;
    @(negedge clk);
    chk("tg_busy_a", 32'(busy_o[0]), 32'd1);
    wr_i[0] = 1'b0; addr_i[0] = 32'h44; din_i[0] = 32'h9999;
    @(negedge clk);
    chk("tg_busy_b", 32'(busy_o[0]), 32'd1);
    chk("tg_nodone", 32'(done_o[0]), 32'd0);
    wr_i[0] = 1'b1; addr_i[0] = 32'h48; din_i[0] = 32'h7777;
    @(negedge clk);
    chk("tg_done1", 32'(done_o[0]), 32'd1);
    chk("tg_fall",  32'(busy_o[0]), 32'd0);
    @(negedge clk);
    chk("tg_accept2", 32'(busy_o[0]), 32'd1);
    req_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tg_done2", 32'(done_o[0]), 32'd1);
    chk("tg_dout_hold", dout_o[0], 32'hDEADBEEF);
    access(0, 1'b0, 32'h40, 32'h0, nb, nd, ne, ead, nc);
    chk("tg_rd40", dout_o[0], 32'h1234);
    access(0, 1'b0, 32'h48, 32'h0, nb, nd, ne, ead, nc);
    chk("tg_rd48", dout_o[0], 32'h7777);

    // Error cases: misaligned read and out-of-range write
    access(0, 1'b1, 32'h0, 32'h12345678, nb, nd, ne, ead, nc);
    access(0, 1'b0, 32'h1002, 32'h0, nb, nd, ne, ead, nc);
    chk("mis_done",   32'(nd),  32'd1);
    chk("mis_errdn",  32'(ead), 32'd1);
    chk("mis_errcnt", 32'(ne),  32'd1);
    chk("mis_data",   dout_o[0], 32'd0);
    access(0, 1'b1, 32'h1000, 32'h5555, nb, nd, ne, ead, nc);
    chk("oor_errdn", 32'(ead), 32'd1);
    access(0, 1'b0, 32'h0, 32'h0, nb, nd, ne, ead, nc);
    chk("oor_noerr", 32'(ne), 32'd0);
    chk("oor_rd0",   dout_o[0], 32'h12345678);

    // Reset during BUSY aborts a pending write
    access(0, 1'b1, 32'h20, 32'hAAAA, nb, nd, ne, ead, nc);
    req_i[0] = 1'b1; wr_i[0] = 1'b1; addr_i[0] = 32'h20; din_i[0] = 32'hBBBB;
    @(negedge clk);
    req_i[0] = 1'b0;
    chk("ab_busy", 32'(busy_o[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ab_rst_busy", 32'(busy_o[0]), 32'd0);
    chk("ab_rst_done", 32'(done_o[0]), 32'd0);
    chk("ab_rst_err",  32'(err_o[0]),  32'd0);
    chk("ab_rst_dout", dout_o[0],      32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(0, 1'b0, 32'h20, 32'h0, nb, nd, ne, ead, nc);
    chk("ab_rd_done", 32'(nd), 32'd1);
    chk("ab_rd20",    dout_o[0], 32'hAAAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
